// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
//   Definitions shared across the 5-stage RISC-V core pipeline.
//   - CTRL_W and the bit position of every flag in the decoded control vector
//     {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp[1:0]}
//   - ALUOp encodings consumed by alu_ctl
//   - small accessor helpers so callers never hard-code bit positions
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int CTRL_W = 8;

    // Bit positions inside the control vector
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    // ALUOp encodings
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10
    } alu_op_e;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // A control vector of all zeros is a bubble: no writes, no memory access,
    // and ALUOp=ADD so alu_ctl stays side-effect free.
    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic logic ctrl_mem_read(input ctrl_t c);
        return c[CTRL_MEMREAD];
    endfunction

    function automatic logic [1:0] ctrl_alu_op(input ctrl_t c);
        return c[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
//   Bundle between the decode stage (master side: drives id_* and flush) and
//   the ID/EX register (slave side: drives ex_*, stall_o and the counters).
//   Parameters
//     XLEN   datapath width of operands, immediate and PC
//     CNT_W  width of the stall/flush event counters
//   Signals
//     id_valid, id_ctrl, id_funct7, id_funct3, id_rs1, id_rs2, id_rd,
//     id_rs1_data, id_rs2_data, id_imm, id_pc, flush    : ID -> ID/EX
//     stall_o, ex_valid, ex_ctrl, ex_alu_op, ex_funct7, ex_funct3, ex_rs1,
//     ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
//     stall_cnt, flush_cnt                               : ID/EX -> core
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    import core_pkg::*;

    // Decode side
    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_funct7;
    logic [2:0]        id_funct3;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [XLEN-1:0]   id_pc;
    logic              flush;

    // Execute side
    logic              stall_o;
    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [1:0]        ex_alu_op;
    logic              ex_funct7;
    logic [2:0]        ex_funct3;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [XLEN-1:0]   ex_imm;
    logic [XLEN-1:0]   ex_pc;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_ctrl, id_funct7, id_funct3, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_pc, flush,
        input  stall_o, ex_valid, ex_ctrl, ex_alu_op, ex_funct7, ex_funct3,
               ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_ctrl, id_funct7, id_funct3, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_pc, flush,
        output stall_o, ex_valid, ex_ctrl, ex_alu_op, ex_funct7, ex_funct3,
               ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//   Purely combinational load-use detector. A load sitting in EX whose
//   destination is read by the instruction in ID forces a one-cycle bubble,
//   because the loaded value only exists after MEM.
//   Ports
//     ex_valid_i     EX slot holds a real instruction
//     ex_mem_read_i  instruction in EX is a load
//     ex_rd_i        destination of the instruction in EX
//     id_valid_i     ID holds a real instruction
//     id_rs1_i       source 1 of the instruction in ID
//     id_rs2_i       source 2 of the instruction in ID
//     stall_o        1 = hold PC and IF/ID, insert a bubble into EX
// ---------------------------------------------------------------------------
module hazard_detect (
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    output logic       stall_o
);

    logic load_in_ex;
    logic src_match;

    // x0 is hardwired to zero, so a load targeting it can never be a producer.
    assign load_in_ex = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0);
    assign src_match  = (ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i);
    assign stall_o    = load_in_ex & id_valid_i & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with load-use hazard detection.
//   Each rising edge, in priority order:
//     flush  -> bubble into EX, flush_cnt saturating increment
//     stall  -> bubble into EX, stall_cnt saturating increment
//     else   -> capture everything from ID, ex_valid = id_valid
//   A bubble clears only ex_valid and ex_ctrl; the payload fields keep their
//   previous contents so the datapath stays deterministic without extra muxing.
//   Parameters
//     XLEN   datapath width (must match the bound interface)
//     CNT_W  event counter width (must match the bound interface)
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; clears every register
//     bus    id_ex_stage_if slave modport (ID inputs, EX outputs, counters)
// ---------------------------------------------------------------------------
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic              ex_valid_q,    ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
    logic              ex_funct7_q,   ex_funct7_d;
    logic [2:0]        ex_funct3_q,   ex_funct3_d;
    logic [4:0]        ex_rs1_q,      ex_rs1_d;
    logic [4:0]        ex_rs2_q,      ex_rs2_d;
    logic [4:0]        ex_rd_q,       ex_rd_d;
    logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
    logic [XLEN-1:0]   ex_imm_q,      ex_imm_d;
    logic [XLEN-1:0]   ex_pc_q,       ex_pc_d;
    logic [CNT_W-1:0]  stall_cnt_q,   stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q,   flush_cnt_d;

    logic              stall;

    // -----------------------------------------------------------------------
    // Load-use detection. Because reset clears ex_valid_q, stall is already
    // low for the whole reset interval without extra gating.
    // -----------------------------------------------------------------------
    hazard_detect u_hazard_detect (
        .ex_valid_i    (ex_valid_q),
        .ex_mem_read_i (ctrl_mem_read(ex_ctrl_q)),
        .ex_rd_i       (ex_rd_q),
        .id_valid_i    (bus.id_valid),
        .id_rs1_i      (bus.id_rs1),
        .id_rs2_i      (bus.id_rs2),
        .stall_o       (stall)
    );

    // -----------------------------------------------------------------------
    // Next-state
    // -----------------------------------------------------------------------
    always_comb begin
        // Hold by default: a bubble leaves the payload untouched.
        ex_valid_d    = ex_valid_q;
        ex_ctrl_d     = ex_ctrl_q;
        ex_funct7_d   = ex_funct7_q;
        ex_funct3_d   = ex_funct3_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_imm_d      = ex_imm_q;
        ex_pc_d       = ex_pc_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;

        if (bus.flush) begin
            // Flush outranks a simultaneous stall; only the flush is counted.
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_BUBBLE;
            if (flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else if (stall) begin
            // The bubble clears ex_valid, so the hazard cannot persist past
            // this one cycle.
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_BUBBLE;
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_valid_d    = bus.id_valid;
            // An empty ID slot must not leak stray write/memory enables.
            ex_ctrl_d     = bus.id_valid ? bus.id_ctrl : CTRL_BUBBLE;
            ex_funct7_d   = bus.id_funct7;
            ex_funct3_d   = bus.id_funct3;
            ex_rs1_d      = bus.id_rs1;
            ex_rs2_d      = bus.id_rs2;
            ex_rd_d       = bus.id_rd;
            ex_rs1_data_d = bus.id_rs1_data;
            ex_rs2_data_d = bus.id_rs2_data;
            ex_imm_d      = bus.id_imm;
            ex_pc_d       = bus.id_pc;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_ctrl_q     <= '0;
            ex_funct7_q   <= 1'b0;
            ex_funct3_q   <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_pc_q       <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_funct7_q   <= ex_funct7_d;
            ex_funct3_q   <= ex_funct3_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_pc_q       <= ex_pc_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.stall_o     = stall;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_ctrl     = ex_ctrl_q;
    assign bus.ex_alu_op   = ctrl_alu_op(ex_ctrl_q);
    assign bus.ex_funct7   = ex_funct7_q;
    assign bus.ex_funct3   = ex_funct3_q;
    assign bus.ex_rs1      = ex_rs1_q;
    assign bus.ex_rs2      = ex_rs2_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_rs1_data = ex_rs1_data_q;
    assign bus.ex_rs2_data = ex_rs2_data_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule
